// File: rtl/tick_pkg.sv
// Shared types for the switch tick injector.
//   tick_t      : one synthetic market tick {side, price, seq}
//   deb_state_e : strobe debounce FSM states
//   SIDE_BUY/SIDE_SELL : encodings of the side bit
package tick_pkg;

  localparam int PRICE_W = 16;
  localparam int SEQ_W   = 8;

  localparam logic SIDE_BUY  = 1'b1;
  localparam logic SIDE_SELL = 1'b0;

  typedef struct packed {
    logic               side;
    logic [PRICE_W-1:0] price;
    logic [SEQ_W-1:0]   seq;
  } tick_t;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } deb_state_e;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with registered occupancy.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   push        : write request; push_data is the entry to store
//   pop         : read request; only honoured while valid
//   head        : current head entry (meaningful while valid)
//   valid       : FIFO holds at least one entry
//   count       : occupancy, 0..DEPTH
//   push_drop   : push was refused because the FIFO was full and not popping
// Handshake: an entry leaves on a clock edge where valid && pop; a push is
// accepted when there is room or a pop frees a slot on the same edge.
module sync_fifo
  import tick_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = tick_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  output T                       head,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   push_drop
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  T                 mem_q [DEPTH];
  T                 mem_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic full;
  logic pop_ok;
  logic push_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign valid   = (count_q != '0);
  assign pop_ok  = pop && valid;
  // A pop on the same edge frees the slot, so a full FIFO still takes the push.
  assign push_ok = push && (!full || pop_ok);

  assign push_drop = push && !push_ok;
  assign head      = mem_q[rd_q];
  assign count     = count_q;

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (push_ok) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_d = rd_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sw_tick_injector.sv
// Turns board switches into synthetic market ticks.
// A debounced rising edge of the strobe switch captures {side, price}, tags
// it with an 8-bit sequence number and queues it in an FWFT FIFO.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   sw_strobe           : raw capture switch (asynchronous)
//   sw_side, sw_price   : raw tick fields (asynchronous)
//   tick_valid/ready    : downstream handshake; transfer on valid && ready
//   tick_side/price/seq : FIFO head, stable while valid && !ready
//   fifo_count          : FIFO occupancy
//   overflow            : sticky, a tick was dropped on a full FIFO
// Debug visibility: deb_state_q holds the debounce FSM state.
module sw_tick_injector
  import tick_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  // Must match the tick_t price field width in tick_pkg.
  parameter int PRICE_W         = tick_pkg::PRICE_W,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sw_strobe,
  input  logic                          sw_side,
  input  logic [PRICE_W-1:0]            sw_price,
  output logic                          tick_valid,
  input  logic                          tick_ready,
  output logic                          tick_side,
  output logic [PRICE_W-1:0]            tick_price,
  output logic [7:0]                    tick_seq,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  // Two-flop synchronizers for every raw switch input.
  logic               strobe_meta_q, strobe_sync_q;
  logic               side_meta_q,   side_sync_q;
  logic [PRICE_W-1:0] price_meta_q,  price_sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      strobe_meta_q <= 1'b0;
      strobe_sync_q <= 1'b0;
      side_meta_q   <= 1'b0;
      side_sync_q   <= 1'b0;
      price_meta_q  <= '0;
      price_sync_q  <= '0;
    end else begin
      strobe_meta_q <= sw_strobe;
      strobe_sync_q <= strobe_meta_q;
      side_meta_q   <= sw_side;
      side_sync_q   <= side_meta_q;
      price_meta_q  <= sw_price;
      price_sync_q  <= price_meta_q;
    end
  end

  // Debounce FSM: a level change is accepted only after DEBOUNCE_CYCLES
  // consecutive samples at the new level; only the accepted rise pushes.
  deb_state_e          deb_state_q, deb_state_d;
  logic [DCNT_W-1:0]   cnt_q, cnt_d;
  logic                push_q, push_d;
  logic                cnt_done;

  assign cnt_done = (cnt_q == DCNT_W'(DEBOUNCE_CYCLES - 1));

  always_comb begin
    deb_state_d = deb_state_q;
    cnt_d       = cnt_q;
    push_d      = 1'b0;
    case (deb_state_q)
      IDLE_LO: begin
        if (strobe_sync_q) begin
          deb_state_d = WAIT_HI;
          cnt_d       = DCNT_W'(1);
        end
      end
      WAIT_HI: begin
        if (!strobe_sync_q) begin
          deb_state_d = IDLE_LO;
        end else if (cnt_done) begin
          deb_state_d = IDLE_HI;
          push_d      = 1'b1;
        end else begin
          cnt_d = cnt_q + DCNT_W'(1);
        end
      end
      IDLE_HI: begin
        if (!strobe_sync_q) begin
          deb_state_d = WAIT_LO;
          cnt_d       = DCNT_W'(1);
        end
      end
      WAIT_LO: begin
        if (strobe_sync_q) begin
          deb_state_d = IDLE_HI;
        end else if (cnt_done) begin
          deb_state_d = IDLE_LO;
        end else begin
          cnt_d = cnt_q + DCNT_W'(1);
        end
      end
      default: deb_state_d = IDLE_LO;
    endcase
  end

  // Tick assembly, sequence numbering and the sticky overflow flag.
  tick_t      push_data;
  tick_t      head;
  logic       push_drop;
  logic [7:0] seq_q, seq_d;
  logic       overflow_q, overflow_d;

  assign push_data = '{side: side_sync_q, price: price_sync_q, seq: seq_q};

  always_comb begin
    seq_d      = seq_q;
    overflow_d = overflow_q;
    // A dropped tick does not consume a sequence number.
    if (push_q && !push_drop) begin
      seq_d = seq_q + 8'd1;
    end
    if (push_drop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      deb_state_q <= IDLE_LO;
      cnt_q       <= '0;
      push_q      <= 1'b0;
      seq_q       <= '0;
      overflow_q  <= 1'b0;
    end else begin
      deb_state_q <= deb_state_d;
      cnt_q       <= cnt_d;
      push_q      <= push_d;
      seq_q       <= seq_d;
      overflow_q  <= overflow_d;
    end
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (tick_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_q),
    .push_data (push_data),
    .pop       (tick_ready),
    .head      (head),
    .valid     (tick_valid),
    .count     (fifo_count),
    .push_drop (push_drop)
  );

  assign tick_side  = head.side;
  assign tick_price = head.price;
  assign tick_seq   = head.seq;
  assign overflow   = overflow_q;

endmodule
